farm_sensor_conditioner: RTL and testbench
==========================================

# farm_sensor_conditioner

- Upstream front end of `traffic_light`: conditions the raw farm-road vehicle loop and drives that controller's `C` input.
- Synchronises and debounces the raw sensor, and latches a vehicle request until the farm light is observed green.
- Counts arrivals and flags a sensor stuck high.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flops on `sensor_raw`; minimum 2.
- `DEBOUNCE_CYCLES`, 4: consecutive equal synchronised samples needed to accept a level change; minimum 2.
- `STUCK_CYCLES`, 1024: consecutive debounced-high cycles before a fault is flagged.
- `COUNT_W`, 8: width of `vehicle_count`.

Ports:
- `clk`  in  1  system clock, 50 MHz, rising edge.
- `rst_n`  in  1  reset: asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
- `sensor_raw`  in  1  raw loop-detector level, asynchronous to `clk`.
- `light_farm`  in  3  farm light fed back from `traffic_light`, encoded {red, yellow, green}; green = 3'b001.
- `C`  out  1  registered farm-road demand into `traffic_light`.
- `vehicle_count`  out  COUNT_W  saturating count of debounced arrivals.
- `sensor_fault`  out  1  debounced sensor has been high for ≥ STUCK_CYCLES.

## Operation
- Synchroniser: `sensor_raw` passes through SYNC_STAGES flops, all reset to 0; the last stage is `s`.
- Debounce FSM states: LOW, CONFIRM_HIGH, HIGH, CONFIRM_LOW.
  - Debounced level `db` = 1 in HIGH and CONFIRM_LOW.
  - The counter `cnt` has width clog2(DEBOUNCE_CYCLES)+1.
  - LOW: if `s`=1, go to CONFIRM_HIGH with `cnt`=1.
  - CONFIRM_HIGH: if `s`=0, go to LOW. If `cnt`==DEBOUNCE_CYCLES-1, go to HIGH. Otherwise increment `cnt`.
  - HIGH and CONFIRM_LOW mirror LOW and CONFIRM_HIGH with the polarity inverted.
- Arrival: pulses for one cycle on the CONFIRM_HIGH→HIGH transition.
- `vehicle_count`: increments on each arrival and saturates at 2^COUNT_W-1; it never wraps.
- Farm green: `fg` = (`light_farm` == 3'b001). Any other encoding, including illegal ones, means not green.
- Request latch `req`:
  - Set on an arrival when `fg`=0.
  - Cleared on any cycle with `fg`=1.
  - When an arrival and `fg`=1 occur on the same cycle, clear wins. The vehicle is served by the current green.
- Stuck detector:
  - Counter clears whenever `db`=0 and increments while `db`=1, saturating at STUCK_CYCLES.
  - `sensor_fault`=1 when the count equals STUCK_CYCLES. It stays 1 until `db` returns to 0, then clears on the next edge.
- Demand: `C` is registered with next value `req | (db & ~sensor_fault)`.
  - A continuously present vehicle holds demand.
  - A stuck loop stops holding demand once flagged.
  - A request already latched persists until the next farm green.

## Timing
- Reset (async, `rst_n`=0):
  - All synchroniser flops = 0; FSM = LOW; `cnt` = 0; `req` = 0; stuck counter = 0.
  - Outputs: `C`=0, `vehicle_count`=0, `sensor_fault`=0.
  - Reset applies immediately, including mid-debounce or mid-request.
  - Release takes effect on the first `clk` edge after `rst_n` goes high.
- Rise latency: with `sensor_raw` rising before edge 1 and held, `db` rises at edge SYNC_STAGES+DEBOUNCE_CYCLES. `C` rises one edge later. Defaults: edge 6 and edge 7.
- Fall latency: identical to rise latency. After a fall, `C` stays 1 if `req`=1.
- Glitch rejection: a high pulse covering fewer than DEBOUNCE_CYCLES consecutive `s` samples gives no arrival, no count and no `C`. Defaults: pulses of 3 cycles (60 ns) or less are rejected.
- `fg` is synchronous to `clk`; it is not synchronised. A `req` clear is visible on `C` one edge after `fg` is sampled.
- Fault: `sensor_fault` rises STUCK_CYCLES edges after `db` rises. `C` drops the following edge, provided `req`=0.

## Test plan
1. Reset mid-debounce: raise `sensor_raw` and assert `rst_n`=0 after edge 4 → `C`=0, `vehicle_count`=0, `sensor_fault`=0 immediately. After release with `sensor_raw` still high, `C` rises at edge 7 after release.
2. Basic arrival: `light_farm`=3'b100, raise `sensor_raw` for 200 ns, then drop → `C`=1 at edge 7, `vehicle_count`=1. `C` stays 1 after the sensor falls until `light_farm`=3'b001 is sampled, then `C`=0 one edge later.
3. Glitch: pulses of 20, 40 and 60 ns, plus a 50 ns pulse → `C` stays 0 and `vehicle_count`=0. An 80 ns pulse → `vehicle_count`=1.
4. Arrival during green: `light_farm`=3'b001, debounced arrival and green on the same cycle → `vehicle_count` increments and `req` stays 0. `C` follows `db` only: 1 while the sensor is held, 0 after the debounced fall with no latched request.
5. Saturation: 300 clean arrivals with COUNT_W=8 → `vehicle_count`=255, no wrap.
6. Stuck sensor: STUCK_CYCLES=16, hold `sensor_raw`=1 with `light_farm`=3'b001 so `req` is cleared → `sensor_fault`=1 16 edges after `db` rises and `C`=0 on the next edge. Release the sensor → `sensor_fault`=0 one edge after `db` falls.

Source files
------------

// File: rtl/farm_sensor_conditioner.sv
// farm_sensor_conditioner
//
// Front end for the farm-road vehicle loop that feeds traffic_light.C. It
// synchronises and debounces the raw loop level, then latches a vehicle
// request until the farm light is seen green. It also counts debounced
// arrivals and flags a loop that stays high too long.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   sensor_raw    in   raw loop-detector level, asynchronous to clk
//   light_farm    in   farm light {red, yellow, green}; green is 3'b001
//   C             out  registered farm-road demand
//   vehicle_count out  saturating count of debounced arrivals
//   sensor_fault  out  debounced level has been high for STUCK_CYCLES cycles
module farm_sensor_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STUCK_CYCLES    = 1024,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sensor_raw,
    input  logic [2:0]         light_farm,
    output logic               C,
    output logic [COUNT_W-1:0] vehicle_count,
    output logic               sensor_fault
);

    localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned StuckW = $clog2(STUCK_CYCLES + 1);

    localparam logic [CntW-1:0]   CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_CYCLES);

    typedef enum logic [1:0] {
        StLow,
        StConfirmHigh,
        StHigh,
        StConfirmLow
    } db_state_e;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM. db_q is kept as a registered copy of
    // (state in StHigh or StConfirmLow).
    // ------------------------------------------------------------------
    db_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic            db_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLow;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StLow: begin
                    if (s) begin
                        state_q <= StConfirmHigh;
                        cnt_q   <= CntW'(1);
                    end
                end
                StConfirmHigh: begin
                    if (!s) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                        db_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StHigh: begin
                    if (!s) begin
                        state_q <= StConfirmLow;
                        cnt_q   <= CntW'(1);
                    end
                end
                StConfirmLow: begin
                    if (s) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                        db_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StLow;
                    cnt_q   <= '0;
                    db_q    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Arrival, request latch, stuck detector and demand
    // ------------------------------------------------------------------
    logic               arrival;
    logic               fg;
    logic               fault;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               req_q, req_d;
    logic [StuckW-1:0]  stuck_q, stuck_d;
    logic               c_q, c_d;

    always_comb begin
        // Same condition that moves the FSM from StConfirmHigh to StHigh.
        arrival = (state_q == StConfirmHigh) && s && (cnt_q == CntLast);
        fg      = (light_farm == 3'b001);
        fault   = (stuck_q == StuckMax);

        count_d = count_q;
        if (arrival && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + COUNT_W'(1);
        end

        // Green clears even when an arrival lands on the same cycle: the
        // current green serves that vehicle.
        req_d = req_q;
        if (fg) begin
            req_d = 1'b0;
        end else if (arrival) begin
            req_d = 1'b1;
        end

        stuck_d = stuck_q;
        if (!db_q) begin
            stuck_d = '0;
        end else if (!fault) begin
            stuck_d = stuck_q + StuckW'(1);
        end

        // A flagged loop no longer holds demand, but a latched request does.
        c_d = req_q | (db_q & ~fault);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            req_q   <= 1'b0;
            stuck_q <= '0;
            c_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            req_q   <= req_d;
            stuck_q <= stuck_d;
            c_q     <= c_d;
        end
    end

    assign C             = c_q;
    assign vehicle_count = count_q;
    assign sensor_fault  = fault;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Directed self-checking bench for farm_sensor_conditioner (20 ns clock,
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STUCK_CYCLES=16, COUNT_W=8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// "edge n" below counts rising edges after the edge at which the stimulus
// was applied.
module tb_farm_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor_raw = 1'b0;
    logic [2:0] light_farm = 3'b100;
    logic       c_out;
    logic [7:0] vehicle_count;
    logic       sensor_fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    farm_sensor_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .STUCK_CYCLES    (16),
        .COUNT_W         (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sensor_raw    (sensor_raw),
        .light_farm    (light_farm),
        .C             (c_out),
        .vehicle_count (vehicle_count),
        .sensor_fault  (sensor_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        sensor_raw = 1'b0;
        light_farm = 3'b100;
        tick(2);
        #5 rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        // ---------------- 1: reset mid-debounce ----------------
        do_reset();
        check("rst_C", c_out, 0);
        check("rst_count", vehicle_count, 0);
        check("rst_fault", sensor_fault, 0);
        sensor_raw = 1'b1;
        tick(4);
        #5 rst_n = 1'b0;
        #1;
        check("t1_midrst_C", c_out, 0);
        check("t1_midrst_count", vehicle_count, 0);
        check("t1_midrst_fault", sensor_fault, 0);
        #3 rst_n = 1'b1;
        tick(6);
        check("t1_e6_C", c_out, 0);
        check("t1_e6_count", vehicle_count, 1);
        tick(1);
        check("t1_e7_C", c_out, 1);
        // Asynchronous assert while a request is latched clears at once.
        #5 rst_n = 1'b0;
        #1;
        check("t1_async_C", c_out, 0);
        check("t1_async_count", vehicle_count, 0);

        // ---------------- 2: basic arrival ----------------
        do_reset();
        sensor_raw = 1'b1;
        tick(6);
        check("t2_e6_C", c_out, 0);
        tick(1);
        check("t2_e7_C", c_out, 1);
        check("t2_e7_count", vehicle_count, 1);
        tick(3);
        sensor_raw = 1'b0;            // 200 ns high
        tick(10);                     // edge 20: db fell at 16, req holds C
        check("t2_held_C", c_out, 1);
        light_farm = 3'b011;          // illegal encoding is not green
        tick(2);
        check("t2_illegal_C", c_out, 1);
        light_farm = 3'b001;
        tick(1);
        check("t2_green_e1_C", c_out, 1);
        tick(1);
        check("t2_green_e2_C", c_out, 0);
        check("t2_count", vehicle_count, 1);
        light_farm = 3'b100;

        // ---------------- 3: glitch rejection ----------------
        do_reset();
        for (int w = 1; w <= 3; w++) begin
            sensor_raw = 1'b1;
            tick(w);
            sensor_raw = 1'b0;
            tick(10);
            check($sformatf("t3_glitch%0d_C", w), c_out, 0);
            check($sformatf("t3_glitch%0d_count", w), vehicle_count, 0);
        end
        // 50 ns pulse placed to straddle three sampling edges.
        #14 sensor_raw = 1'b1;
        #50 sensor_raw = 1'b0;
        tick(10);
        check("t3_50ns_C", c_out, 0);
        check("t3_50ns_count", vehicle_count, 0);
        sensor_raw = 1'b1;            // 80 ns: four samples, accepted
        tick(4);
        sensor_raw = 1'b0;
        tick(10);
        check("t3_80ns_count", vehicle_count, 1);
        check("t3_80ns_C", c_out, 1);

        // ---------------- 4: arrival during green ----------------
        do_reset();
        light_farm = 3'b001;
        sensor_raw = 1'b1;
        tick(6);
        check("t4_e6_count", vehicle_count, 1);
        // Going red right after the arrival exposes any latched request.
        light_farm = 3'b100;
        tick(1);
        check("t4_e7_C", c_out, 1);
        tick(3);
        sensor_raw = 1'b0;
        tick(6);
        check("t4_e16_C", c_out, 1);
        tick(1);
        check("t4_e17_C", c_out, 0);
        check("t4_count", vehicle_count, 1);

        // ---------------- 5: count saturation ----------------
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            sensor_raw = 1'b1;
            tick(5);
            sensor_raw = 1'b0;
            tick(6);
            if (i == 100 || i == 255 || i == 256 || i == 300) begin
                check($sformatf("t5_count_%0d", i), vehicle_count, (i > 255) ? 255 : i);
            end
        end

        // ---------------- 6: stuck sensor ----------------
        do_reset();
        light_farm = 3'b001;
        sensor_raw = 1'b1;
        tick(21);
        check("t6_e21_fault", sensor_fault, 0);
        check("t6_e21_C", c_out, 1);
        tick(1);
        check("t6_e22_fault", sensor_fault, 1);
        check("t6_e22_C", c_out, 1);
        tick(1);
        check("t6_e23_C", c_out, 0);
        tick(10);
        check("t6_e33_fault", sensor_fault, 1);
        check("t6_e33_C", c_out, 0);
        sensor_raw = 1'b0;
        tick(6);                      // db falls here
        check("t6_dbfall_fault", sensor_fault, 1);
        tick(1);
        check("t6_clear_fault", sensor_fault, 0);
        check("t6_clear_C", c_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
